// File: rtl/sipo_deserializer_if.sv
// sipo_deserializer_if
//   Bundles the serial link inputs and the parallel valid/ready output of
//   the SIPO deserializer.
//   master : deserializer side (consumes the serial bits, drives the word and
//            status flags)
//   slave  : environment side (drives the serial bits and out_ready)
//   Signals: serial_in, serial_valid, frame_start, out_ready (to deserializer)
//            parallel_out[WIDTH-1:0], out_valid, busy, frame_error, overrun
//            (from deserializer)
interface sipo_deserializer_if #(
    parameter int unsigned WIDTH = 4
);
    logic             serial_in;
    logic             serial_valid;
    logic             frame_start;
    logic             out_ready;
    logic [WIDTH-1:0] parallel_out;
    logic             out_valid;
    logic             busy;
    logic             frame_error;
    logic             overrun;

    modport master (
        input  serial_in, serial_valid, frame_start, out_ready,
        output parallel_out, out_valid, busy, frame_error, overrun
    );

    modport slave (
        output serial_in, serial_valid, frame_start, out_ready,
        input  parallel_out, out_valid, busy, frame_error, overrun
    );
endinterface

// File: rtl/sipo_deserializer.sv
// sipo_deserializer
//   Receive end of the MSB-first serial link. Collects WIDTH bits, aligned by
//   frame_start, into a word and presents it on a valid/ready output register.
//   Ports:
//     clock  : system clock, rising edge
//     reset  : synchronous, active-high; discards any partial or held word
//     bus    : sipo_deserializer_if.master
//              serial_in/serial_valid/frame_start : serial link, MSB first
//              parallel_out/out_valid/out_ready   : word output handshake
//              busy        : partial word in progress
//              frame_error : one-cycle pulse, frame_start arrived mid-word
//              overrun     : sticky, a completed word was dropped
module sipo_deserializer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    sipo_deserializer_if.master     bus
);
    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        HUNT,
        SHIFT
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             frame_error_q, frame_error_d;
    logic             overrun_q, overrun_d;

    logic [WIDTH-1:0] shifted;
    logic             word_done;
    logic             transfer;

    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        shift_d       = shift_q;
        data_d        = data_q;
        valid_d       = valid_q;
        overrun_d     = overrun_q;
        frame_error_d = 1'b0;
        word_done     = 1'b0;
        shifted       = {shift_q[WIDTH-2:0], bus.serial_in};
        transfer      = valid_q && bus.out_ready;

        if (bus.serial_valid) begin
            if (bus.frame_start) begin
                // Restart alignment; only an error if a word was partially
                // collected.
                if (state_q == SHIFT && count_q != '0) begin
                    frame_error_d = 1'b1;
                end
                state_d = SHIFT;
                count_d = CW'(1);
                shift_d = {{(WIDTH-1){1'b0}}, bus.serial_in};
            end else if (state_q == SHIFT) begin
                shift_d = shifted;
                if (count_q == LAST) begin
                    word_done = 1'b1;
                    count_d   = '0;
                end else begin
                    count_d = count_q + CW'(1);
                end
            end
        end

        // A completion may reuse the output register on the same edge it is
        // being drained; otherwise the held word wins and the new one is lost.
        if (word_done) begin
            if (!valid_q || transfer) begin
                data_d  = shifted;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (transfer) begin
            valid_d = 1'b0;
        end

        busy_d = (count_d != '0);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= HUNT;
            count_q       <= '0;
            shift_q       <= '0;
            data_q        <= '0;
            valid_q       <= 1'b0;
            busy_q        <= 1'b0;
            frame_error_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            shift_q       <= shift_d;
            data_q        <= data_d;
            valid_q       <= valid_d;
            busy_q        <= busy_d;
            frame_error_q <= frame_error_d;
            overrun_q     <= overrun_d;
        end
    end

    assign bus.parallel_out = data_q;
    assign bus.out_valid    = valid_q;
    assign bus.busy         = busy_q;
    assign bus.frame_error  = frame_error_q;
    assign bus.overrun      = overrun_q;
endmodule

// File: tb/tb_sipo_deserializer.sv
module tb_sipo_deserializer;
    logic clock;
    logic reset;
    int   checks;
    int   failures;

    sipo_deserializer_if #(.WIDTH(4)) bus ();

    sipo_deserializer #(.WIDTH(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Apply one cycle of inputs; returns 1 time unit after the edge that
    // consumed them, so outputs reflect that edge.
    task automatic drive(input logic v, input logic fs, input logic b, input logic rdy);
        bus.serial_valid = v;
        bus.frame_start  = fs;
        bus.serial_in    = b;
        bus.out_ready    = rdy;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus.parallel_out !== 4'b0000) begin
            $display("FAIL reset_parallel_out got=%b want=0000", bus.parallel_out); failures++;
        end
        checks++;
        if ({bus.out_valid, bus.busy, bus.frame_error, bus.overrun} !== 4'b0000) begin
            $display("FAIL reset_flags got=%b want=0000 (valid,busy,ferr,ovr)",
                     {bus.out_valid, bus.busy, bus.frame_error, bus.overrun}); failures++;
        end
    endtask

    task automatic test_basic_word();
        do_reset();
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (bus.busy !== 1'b1) begin
            $display("FAIL basic_busy_mid got=%b want=1", bus.busy); failures++;
        end
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        checks++;
        if (bus.parallel_out !== 4'b1011 || bus.out_valid !== 1'b1 || bus.busy !== 1'b0) begin
            $display("FAIL basic_word got=%b valid=%b busy=%b want=1011 valid=1 busy=0",
                     bus.parallel_out, bus.out_valid, bus.busy); failures++;
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (bus.parallel_out !== 4'b1011 || bus.out_valid !== 1'b1) begin
            $display("FAIL basic_hold got=%b valid=%b want=1011 valid=1",
                     bus.parallel_out, bus.out_valid); failures++;
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            $display("FAIL basic_consume got valid=%b want=0", bus.out_valid); failures++;
        end
    endtask

    task automatic test_hunt();
        do_reset();
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b1, 1'b0);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            $display("FAIL hunt_ignore got valid=%b busy=%b want valid=0 busy=0",
                     bus.out_valid, bus.busy); failures++;
        end
        // frame_start without serial_valid must not start a word
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        checks++;
        if (bus.busy !== 1'b0) begin
            $display("FAIL hunt_fs_no_valid got busy=%b want=0", bus.busy); failures++;
        end
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (bus.parallel_out !== 4'b0110 || bus.out_valid !== 1'b1) begin
            $display("FAIL hunt_word got=%b valid=%b want=0110 valid=1",
                     bus.parallel_out, bus.out_valid); failures++;
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b1, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        checks++;
        if (bus.parallel_out !== 4'b1010 || bus.out_valid !== 1'b1) begin
            $display("FAIL b2b_word1 got=%b valid=%b want=1010 valid=1",
                     bus.parallel_out, bus.out_valid); failures++;
        end
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b1) begin
            $display("FAIL b2b_drain got valid=%b busy=%b want valid=0 busy=1",
                     bus.out_valid, bus.busy); failures++;
        end
        drive(1'b1, 1'b0, 1'b1, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b1, 1'b1);
        checks++;
        if (bus.parallel_out !== 4'b0101 || bus.out_valid !== 1'b1 || bus.overrun !== 1'b0) begin
            $display("FAIL b2b_word2 got=%b valid=%b ovr=%b want=0101 valid=1 ovr=0",
                     bus.parallel_out, bus.out_valid, bus.overrun); failures++;
        end
    endtask

    task automatic test_frame_error();
        do_reset();
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        checks++;
        if (bus.frame_error !== 1'b0) begin
            $display("FAIL ferr_first_fs got=%b want=0", bus.frame_error); failures++;
        end
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if (bus.frame_error !== 1'b1 || bus.busy !== 1'b1) begin
            $display("FAIL ferr_pulse got ferr=%b busy=%b want ferr=1 busy=1",
                     bus.frame_error, bus.busy); failures++;
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (bus.frame_error !== 1'b0) begin
            $display("FAIL ferr_one_cycle got=%b want=0", bus.frame_error); failures++;
        end
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        checks++;
        if (bus.parallel_out !== 4'b0011 || bus.out_valid !== 1'b1) begin
            $display("FAIL ferr_word got=%b valid=%b want=0011 valid=1",
                     bus.parallel_out, bus.out_valid); failures++;
        end
        // frame_start on a word boundary is legal
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        checks++;
        if (bus.frame_error !== 1'b0) begin
            $display("FAIL ferr_boundary_fs got=%b want=0", bus.frame_error); failures++;
        end
    endtask

    task automatic test_overrun();
        do_reset();
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        checks++;
        if (bus.overrun !== 1'b1 || bus.parallel_out !== 4'b1100 || bus.out_valid !== 1'b1) begin
            $display("FAIL ovr_set got ovr=%b out=%b valid=%b want ovr=1 out=1100 valid=1",
                     bus.overrun, bus.parallel_out, bus.out_valid); failures++;
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (bus.overrun !== 1'b1 || bus.out_valid !== 1'b0) begin
            $display("FAIL ovr_sticky got ovr=%b valid=%b want ovr=1 valid=0",
                     bus.overrun, bus.out_valid); failures++;
        end
        // Completion on the same edge as the transfer replaces the word
        do_reset();
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b1);
        checks++;
        if (bus.overrun !== 1'b0 || bus.parallel_out !== 4'b0011 || bus.out_valid !== 1'b1) begin
            $display("FAIL ovr_same_edge got ovr=%b out=%b valid=%b want ovr=0 out=0011 valid=1",
                     bus.overrun, bus.parallel_out, bus.out_valid); failures++;
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        reset = 1'b0;
        checks++;
        if ({bus.out_valid, bus.busy, bus.frame_error, bus.overrun} !== 4'b0000) begin
            $display("FAIL rst_mid_flags got=%b want=0000",
                     {bus.out_valid, bus.busy, bus.frame_error, bus.overrun}); failures++;
        end
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b1, 1'b0);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            $display("FAIL rst_mid_hunt got valid=%b busy=%b want valid=0 busy=0",
                     bus.out_valid, bus.busy); failures++;
        end
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.parallel_out !== 4'b1111) begin
            $display("FAIL rst_pre_word got=%b valid=%b want=1111 valid=1",
                     bus.parallel_out, bus.out_valid); failures++;
        end
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        checks++;
        if (bus.parallel_out !== 4'b0000 || bus.out_valid !== 1'b0) begin
            $display("FAIL rst_valid_discard got=%b valid=%b want=0000 valid=0",
                     bus.parallel_out, bus.out_valid); failures++;
        end
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            $display("FAIL rst_valid_hunt got valid=%b busy=%b want valid=0 busy=0",
                     bus.out_valid, bus.busy); failures++;
        end
    endtask

    initial begin
        checks           = 0;
        failures         = 0;
        reset            = 1'b1;
        bus.serial_valid = 1'b0;
        bus.frame_start  = 1'b0;
        bus.serial_in    = 1'b0;
        bus.out_ready    = 1'b0;
        test_reset();
        test_basic_word();
        test_hunt();
        test_back_to_back();
        test_frame_error();
        test_overrun();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
